// File: rtl/caravel_ips_wb_ctrl.sv
`timescale 1ns/1ps
// Management Wishbone to per-IP channel controller: decode, run one access, return ack/data.
// Hit ack at 2+L cycles, miss ack at 1 cycle; the IP wait is bounded by TIMEOUT and answered with ERR_DATA.
module caravel_ips_wb_ctrl #(
    parameter int          NSLV     = 4,
    parameter int          WIN_AW   = 16,
    parameter logic [31:0] BASE     = 32'h3000_0000,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NSLV-1:0]      ip_cyc_o,
    output logic [NSLV-1:0]      ip_stb_o,
    output logic                 ip_we_o,
    output logic [3:0]           ip_sel_o,
    output logic [WIN_AW-1:0]    ip_adr_o,
    output logic [31:0]          ip_dat_o,
    input  logic [32*NSLV-1:0]   ip_dat_i,
    input  logic [NSLV-1:0]      ip_ack_i,
    output logic                 timeout_o
);

    localparam int SW = $clog2(NSLV);
    localparam int HB = WIN_AW + SW;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     idx_q;
    logic [7:0]        cnt_q;
    logic              ack_q;
    logic              to_q;
    logic [31:0]       rdat_q;
    logic [NSLV-1:0]   cyc_q;
    logic [NSLV-1:0]   stb_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [WIN_AW-1:0] adr_q;
    logic [31:0]       wdat_q;

    logic              req;
    logic              hit;
    logic [SW-1:0]     req_idx;
    logic              sel_ack;
    logic [31:0]       sel_dat;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign hit     = (wbs_adr_i[31:HB] == BASE[31:HB]);
    assign req_idx = wbs_adr_i[HB-1:WIN_AW];
    assign sel_ack = ip_ack_i[idx_q];

    // Only the latched target's data is ever forwarded to the SoC.
    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (idx_q == SW'(k)) begin
                sel_dat = ip_dat_i[32*k +: 32];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
            rdat_q  <= '0;
            cyc_q   <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack_q <= 1'b0;
                    to_q  <= 1'b0;
                    if (req) begin
                        if (hit) begin
                            idx_q   <= req_idx;
                            we_q    <= wbs_we_i;
                            sel_q   <= wbs_sel_i;
                            adr_q   <= wbs_adr_i[WIN_AW-1:0];
                            wdat_q  <= wbs_dat_i;
                            cyc_q   <= NSLV'(1) << req_idx;
                            stb_q   <= NSLV'(1) << req_idx;
                            cnt_q   <= '0;
                            state_q <= BUSY;
                        end else begin
                            rdat_q  <= ERR_DATA;
                            to_q    <= 1'b1;
                            ack_q   <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                BUSY: begin
                    // SoC abort takes priority: the access is dropped silently.
                    if (!wbs_cyc_i) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        state_q <= IDLE;
                    end else if (sel_ack) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        rdat_q  <= sel_dat;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        cyc_q   <= '0;
                        stb_q   <= '0;
                        rdat_q  <= ERR_DATA;
                        to_q    <= 1'b1;
                        ack_q   <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    ack_q   <= 1'b0;
                    to_q    <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign timeout_o = to_q;
    assign ip_cyc_o  = cyc_q;
    assign ip_stb_o  = stb_q;
    assign ip_we_o   = we_q;
    assign ip_sel_o  = sel_q;
    assign ip_adr_o  = adr_q;
    assign ip_dat_o  = wdat_q;

endmodule
